tt_um_micro_gfg_development_pdm_tx: RTL and testbench

Micro-tile PDM transmitter: the transmit-side counterpart of the team's CIC PDM decimator. It accepts a 7-bit two's-complement sample at a low rate, upsamples it with an interpolating CIC filter (comb stages at the sample rate, zero-stuffing, integrator stages at the clock rate) and converts the result into a 1-bit pulse-density stream with a first-order sigma-delta modulator. It drives a PDM DAC or speaker directly, or provides loopback stimulus for the decimator tile.

---
 rtl/tt_um_micro_gfg_development_pdm_tx.sv | 61 ++++++
 tb/tb_tt_um_micro_gfg_development_pdm_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/tt_um_micro_gfg_development_pdm_tx.sv
// tt_um_micro_gfg_development_pdm_tx: CIC interpolator feeding a first-order sigma-delta PDM modulator
module tt_um_micro_gfg_development_pdm_tx #(
  parameter int STAGES      = 2,
  parameter int LOG2_INTERP = 4,
  parameter int WIDTH_IN    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);
  localparam int WIDTH_OUT  = WIDTH_IN + (STAGES - 1) * LOG2_INTERP;
  localparam int WIDTH_REGS = WIDTH_IN + STAGES * LOG2_INTERP;
  logic                   en, strobe, pdm;
  logic [LOG2_INTERP-1:0] ctr;
  logic [WIDTH_IN-1:0]    x_reg;
  logic [WIDTH_REGS-1:0]  comb_buf [STAGES];
  logic [WIDTH_REGS-1:0]  comb_next [STAGES];
  logic [WIDTH_REGS-1:0]  int_buf [STAGES];
  logic [WIDTH_REGS-1:0]  int_next [STAGES];
  logic [WIDTH_REGS-1:0]  c, s;
  logic [WIDTH_OUT-1:0]   y, u, acc;
  assign en     = ui_in[0];
  assign strobe = ctr == '0;
  // comb chain runs on held x_reg; the zero-stuffed result feeds the integrator chain every clk
  always_comb begin
    c = {{(WIDTH_REGS - WIDTH_IN){x_reg[WIDTH_IN-1]}}, x_reg};
    for (int j = 0; j < STAGES; j++) begin
      comb_next[j] = c;
      c = c - comb_buf[j];
    end
    s = strobe ? c : '0;
    for (int j = 0; j < STAGES; j++) begin
      s = s + int_buf[j];
      int_next[j] = s;
    end
  end
  assign y      = s[WIDTH_OUT-1:0];
  assign u      = {~y[WIDTH_OUT-1], y[WIDTH_OUT-2:0]};
  assign uo_out = {y[WIDTH_OUT-1 -: 5], en, strobe, pdm};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr      <= '0;
      x_reg    <= '0;
      comb_buf <= '{default: '0};
      int_buf  <= '{default: '0};
      acc      <= '0;
      pdm      <= 1'b0;
    end else if (en) begin
      ctr        <= ctr + 1'b1;
      {pdm, acc} <= {1'b0, acc} + {1'b0, u};
      int_buf    <= int_next;
      if (ctr == '1) begin
        x_reg    <= ui_in[7:1];
        comb_buf <= comb_next;
      end
    end else begin
      pdm <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tt_um_micro_gfg_development_pdm_tx.sv
// tb_tt_um_micro_gfg_development_pdm_tx: directed checks of the PDM transmitter against a linear-interpolation model
module tb_tt_um_micro_gfg_development_pdm_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  int passed = 0;
  int total  = 0;
  int m_ctr, m_xk, m_xp, m_acc, ones;
  logic m_pdm;
  logic signed [6:0] xs;
  tt_um_micro_gfg_development_pdm_tx dut (.clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  // two-stage CIC interpolation is linear interpolation: phase m weights the newest sample by m+1, the previous by R-1-m
  function automatic int model_y();
    return (m_ctr + 1) * m_xk + (15 - m_ctr) * m_xp;
  endfunction
  function automatic logic [7:0] model_out();
    int yi;
    logic [10:0] yv;
    yi = model_y();
    yv = yi[10:0];
    return {yv[10:6], ui_in[0], m_ctr == 0, m_pdm};
  endfunction
  task automatic model_reset();
    m_ctr = 0; m_xk = 0; m_xp = 0; m_acc = 0; m_pdm = 1'b0;
  endtask
  task automatic model_edge();
    int sum;
    logic signed [6:0] xv;
    if (ui_in[0]) begin
      sum   = m_acc + model_y() + 1024;
      m_pdm = sum >= 2048;
      m_acc = sum % 2048;
      if (m_ctr == 15) begin
        xv   = ui_in[7:1];
        m_xp = m_xk;
        m_xk = int'(xv);
      end
      m_ctr = (m_ctr + 1) % 16;
    end else begin
      m_pdm = 1'b0;
    end
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check(tag, uo_out, model_out());
  endtask
  initial begin
    rst_n = 1'b0;
    ui_in = 8'h01;
    model_reset();
    #3;
    check("rst_hold", uo_out, 8'h06);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel", uo_out, 8'h06);
    for (int k = 1; k <= 64; k++) begin
      tick("idle");
      check("idle_pdm", uo_out[0], k % 2 == 0);
      check("idle_stb", uo_out[1], k % 16 == 0);
    end
    ui_in = {7'd63, 1'b1};
    repeat (16) tick("cap63");
    for (int m = 0; m < 16; m++) begin
      check("ramp63", uo_out[7:3], (63 * (m + 1)) >> 6);
      tick("ramp63_t");
    end
    ones = 0;
    for (int k = 0; k < 2048; k++) begin
      tick("hold63");
      ones += uo_out[0];
    end
    check("ones63", ones, 2032);
    ui_in = {7'h40, 1'b1};
    repeat (32) tick("neg_settle");
    ones = 0;
    for (int k = 0; k < 2048; k++) begin
      tick("hold_neg");
      ones += uo_out[0];
    end
    check("ones_neg", ones, 0);
    check("msb_neg", uo_out[7:3], 5'b10000);
    for (int p = 0; p < 8; p++) begin
      xs = (p % 2 == 1) ? -7'sd32 : 7'sd32;
      ui_in = {xs, 1'b1};
      repeat (16) tick("alt");
    end
    ui_in = {7'd40, 1'b1};
    repeat (32) tick("set40");
    check("msb40", uo_out[7:3], 5'd10);
    repeat (5) tick("pre_gap");
    ui_in[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick("gap");
      check("gap_out", uo_out, {5'd10, 3'b000});
    end
    ui_in[0] = 1'b1;
    repeat (2) tick("resume");
    check("ctr7_msb", uo_out[7:3], 5'd10);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst", uo_out, 8'h06);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel2", uo_out, 8'h06);
    for (int k = 1; k <= 32; k++) begin
      tick("restart");
      if (k == 15) check("pre_cap", uo_out[7:1], 7'b0000010);
      if (k == 16) check("cap_stb", uo_out[1], 1'b1);
      if (k == 17) check("step_m1", uo_out[7:3], 5'd1);
      if (k == 31) check("step_m15", uo_out[7:3], 5'd10);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
